// File: rtl/mont_dil_scheduler_pkg.sv
// rtl/mont_dil_scheduler_pkg.sv - shared NTT constants for the Dilithium Montgomery scheduler
package mont_dil_scheduler_pkg;

  // Dilithium modulus and its inverse modulo 2^32
  localparam int unsigned DIL_Q      = 32'd8380417;
  localparam int unsigned DIL_QINV   = 32'd58728449;

  // Operand stage (S1) followed by result stage (S2)
  localparam int unsigned PIPE_DEPTH = 2;

  // Requester index width, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/montgomery_dilithium.sv
// rtl/montgomery_dilithium.sv - combinational Dilithium Montgomery reduction
module montgomery_dilithium
  import mont_dil_scheduler_pkg::*;
#(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = INPUT_SIZE/2
) (
  input  logic [INPUT_SIZE-1:0]  a_i,
  output logic [OUTPUT_SIZE-1:0] res_o
);

  logic [31:0]            t;
  logic signed [55:0]     t_ext;
  logic signed [55:0]     q_ext;
  logic signed [55:0]     tq;
  logic [INPUT_SIZE-1:0]  diff;

  // t = a*QINV mod 2^32, reinterpreted as signed; t*Q cancels the low 32 bits of a
  always_comb begin
    t     = a_i[31:0] * DIL_QINV[31:0];
    t_ext = 56'($signed(t));
    q_ext = 56'(DIL_Q);
    tq    = t_ext * q_ext;
    diff  = a_i - INPUT_SIZE'(tq);
    res_o = OUTPUT_SIZE'(diff >> 32);
  end

endmodule

// File: rtl/mont_dil_scheduler.sv
// rtl/mont_dil_scheduler.sv - round-robin scheduler sharing one Montgomery reduction pipeline
module mont_dil_scheduler
  import mont_dil_scheduler_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int INPUT_SIZE  = 64,
  parameter  int OUTPUT_SIZE = INPUT_SIZE/2,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] req_data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [OUTPUT_SIZE-1:0]        res_data_o,
  output logic [ID_W-1:0]               res_id_o,
  output logic                          busy_o
);

  // vld_q[0] = S1 occupied, vld_q[1] = S2 occupied
  logic [PIPE_DEPTH-1:0]  vld_q, vld_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [INPUT_SIZE-1:0]  s1_data_q;
  logic [ID_W-1:0]        s1_id_q;
  logic [OUTPUT_SIZE-1:0] s2_data_q;
  logic [ID_W-1:0]        s2_id_q;
  logic [OUTPUT_SIZE-1:0] red_res;

  logic                   s1_adv;
  logic                   s1_free;
  logic                   grant_found;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W:0]          idx;
  logic                   accept;
  logic [INPUT_SIZE-1:0]  req_ops [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_ops[k] = req_data_i[k*INPUT_SIZE +: INPUT_SIZE];
  end

  // Round-robin search from ptr_q upward with wrap; first valid requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_i[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  // Pipeline flow control: S1 moves on when S2 is empty or draining; S1 takes a new
  // operand when empty or moving on. Ready is held low while reset is asserted.
  always_comb begin
    s1_adv      = vld_q[0] & (~vld_q[1] | res_ready_i);
    s1_free     = ~vld_q[0] | s1_adv;
    accept      = grant_found & s1_free & rstn_i;
    req_ready_o = accept ? (NUM_REQ'(1) << grant_id) : '0;

    vld_d = vld_q;
    if (accept) begin
      vld_d[0] = 1'b1;
    end else if (s1_adv) begin
      vld_d[0] = 1'b0;
    end
    if (s1_adv) begin
      vld_d[1] = 1'b1;
    end else if (res_ready_i) begin
      vld_d[1] = 1'b0;
    end

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  montgomery_dilithium #(
    .INPUT_SIZE (INPUT_SIZE),
    .OUTPUT_SIZE(OUTPUT_SIZE)
  ) u_reduce (
    .a_i  (s1_data_q),
    .res_o(red_res)
  );

  // Stage registers and arbitration pointer; reset drops all in-flight work
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q     <= '0;
      ptr_q     <= '0;
      s1_data_q <= '0;
      s1_id_q   <= '0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      if (accept) begin
        s1_data_q <= req_ops[grant_id];
        s1_id_q   <= grant_id;
      end
      if (s1_adv) begin
        s2_data_q <= red_res;
        s2_id_q   <= s1_id_q;
      end
    end
  end

  assign res_valid_o = vld_q[1];
  assign res_data_o  = s2_data_q;
  assign res_id_o    = s2_id_q;
  assign busy_o      = |vld_q;

endmodule
